// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined N-input selector.
// Provides clog2, the default widths and the default counter ceiling.
package mux_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ERR_CNT_W_DEF = 8;
  localparam int ERR_SAT_DEF = (1 << ERR_CNT_W_DEF) - 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One data+valid register of the selector pipeline.
// Ports: clk, rst, stall, flush, prev_valid/prev_data in, valid/data out.
module mux_pipe_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              prev_valid,
  input  logic [DATA_W-1:0] prev_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Data loads only with a valid entry, so bubbles keep the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!stall) begin
      valid <= prev_valid;
      if (prev_valid) data <= prev_data;
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-input selector with DEPTH registered stages, stall/flush and select errors.
// Ports: clk, rst, stall, flush, in_valid, sel, data_in -> mux_out, out_valid, sel_err, err_cnt.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_IN      = 4,
  parameter int SEL_W     = 4,
  parameter int DEPTH     = 1,
  parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_IN*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]      mux_out,
  output logic                   out_valid,
  output logic                   sel_err,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam logic [SEL_W:0] N_IN_V = (SEL_W + 1)'(N_IN);
  localparam logic [ERR_CNT_W-1:0] ERR_SAT = '1;

  logic [DATA_W-1:0] picked;
  logic              oor;
  logic              accept;

  logic [DEPTH:0][DATA_W-1:0] d;
  logic [DEPTH:0]             v;

  // Out-of-range selects fall back to the last input.
  always_comb begin
    picked = data_in[(N_IN-1)*DATA_W +: DATA_W];
    for (int i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) picked = data_in[i*DATA_W +: DATA_W];
    end
  end

  assign oor    = {1'b0, sel} >= N_IN_V;
  assign accept = in_valid & ~stall & ~flush;

  assign d[0] = picked;
  assign v[0] = in_valid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    mux_pipe_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .flush     (flush),
      .prev_valid(v[k]),
      .prev_data (d[k]),
      .valid     (v[k+1]),
      .data      (d[k+1])
    );
  end

  assign mux_out   = d[DEPTH];
  assign out_valid = v[DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else if (accept && oor) begin
      sel_err <= 1'b1;
      if (err_cnt != ERR_SAT) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-input selector with a DEPTH-stage registered output, for pipeline forwarding and operand selection where the select is resolved one or more cycles before use (e.g. multi-cycle MULT operand paths).
- Adds stall hold, flush bubbles and a valid bit travelling with the data.
- Adds out-of-range select detection with a sticky flag and a saturating error counter.
- Sits between the hazard/forwarding unit and EX-stage operand registers.

Parameters:
- DATA_W, 16, width of each data input and of the output.
- N_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, 4, select width; must be >= clog2(N_IN). Values >= N_IN are out-of-range.
- DEPTH, 1, number of output register stages; legal range 1..4.
- ERR_CNT_W, 8, width of the saturating out-of-range counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- stall  in  1  when high, every stage holds data and valid.
- flush  in  1  when high, every valid bit clears to 0 on the next edge.
- in_valid  in  1  qualifies sel and data_in this cycle.
- sel  in  SEL_W  binary input select.
- data_in  in  N_IN*DATA_W  flattened inputs; input i occupies bits [i*DATA_W +: DATA_W].
- mux_out  out  DATA_W  data of the last stage.
- out_valid  out  1  valid bit of the last stage.
- sel_err  out  1  sticky flag: an out-of-range select was accepted.
- err_cnt  out  ERR_CNT_W  count of accepted out-of-range selects, saturating.

Behaviour:
- Reset (rst high at an edge):
  - all stage data = 0 and all valid = 0, so mux_out = 0 and out_valid = 0;
  - sel_err = 0 and err_cnt = 0;
  - rst overrides stall and flush; asserting rst mid-stream discards all in-flight entries.
- Combinational select:
  - sel < N_IN picks data_in slice sel;
  - sel >= N_IN picks slice N_IN-1 (the last input, consistent with the existing 3-input selector's default).
- Accept condition: accept = in_valid & !stall & !flush.
- Stage 0 update when !stall:
  - valid0 <= in_valid & !flush;
  - data0 <= selected value only when accept, otherwise data0 holds.
- Stage k>0 update when !stall:
  - valid_k <= valid_(k-1) & !flush;
  - data_k <= data_(k-1) only when valid_(k-1), otherwise data_k holds;
  - a bubble therefore never overwrites the last valid data.
- Stall high and flush low: all data and valid hold; inputs are ignored.
- Flush high, with or without stall:
  - all valid bits clear on the next edge;
  - data registers hold;
  - the input is not accepted. Flush wins over stall.
- Latency:
  - an accepted input appears at mux_out with out_valid = 1 exactly DEPTH unstalled edges later;
  - each stall cycle adds one cycle of latency;
  - throughput is one item per cycle when not stalled.
- Error tracking:
  - on accept with sel >= N_IN: sel_err <= 1;
  - on the same condition err_cnt increments unless it equals 2^ERR_CNT_W-1, where it saturates;
  - an out-of-range select is not counted when in_valid is low, stall is high or flush is high;
  - only rst clears sel_err and err_cnt.
- Outputs come directly from registers; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package mux_pkg:
  - constant function clog2;
  - default DATA_W;
  - localparam for the err_cnt saturation value.
- One sub-module, mux_pipe_stage:
  - one data+valid register with stall, flush and load-on-valid;
  - instantiated DEPTH times via generate.
- Select decode and error counter stay in mux_n_pipe.

Test Plan:
- Reset and basic latency. Settings: DEPTH=2, N_IN=4, inputs = 0x1111, 0x2222, 0x3333, 0x4444; send sel=2 with in_valid=1, then keep in_valid=0. Required: mux_out = 0x3333 with out_valid = 1 on the 2nd edge after acceptance; out_valid = 0 after that while mux_out holds 0x3333.
- Back-to-back stream. Settings: DEPTH=1; sel = 0,1,2,3 on four consecutive valid cycles. Required: mux_out = 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles with out_valid held at 1.
- Stall. Settings: DEPTH=2; stream sel=0, then sel=1; assert stall for 3 cycles while 0x1111 is in stage 1. Required: outputs frozen for 3 cycles; 0x1111 then 0x2222 appear after stall drops; no loss and no duplication.
- Flush with stall. Settings: two items in flight; assert flush and stall in the same cycle. Required: out_valid = 0 on the next edge; mux_out keeps its last value; input not accepted; err_cnt unchanged.
- Out-of-range select. Settings: N_IN=3, SEL_W=2; accept sel=3 twice, plus sel=3 with stall=1. Required: mux_out = input 2 data; sel_err = 1; err_cnt = 2.
- Counter saturation and reset. Settings: ERR_CNT_W=2; accept 5 out-of-range selects, then pulse rst. Required: err_cnt stops at 3 with sel_err = 1; after rst, err_cnt = 0, sel_err = 0, out_valid = 0, mux_out = 0.
